// File: rtl/blink_pkg.sv
// Shared constants for the selectable-rate blinker.
// Mode and stepping-policy encodings plus the level-width helper.
package blink_pkg;

    localparam int MODE_BLINK = 0;
    localparam int MODE_PWM   = 1;

    localparam int WRAP_SAT   = 0;
    localparam int WRAP_ROLL  = 1;

    // Bits needed to hold a level value in 1..levels.
    function automatic int lvl_w(input int levels);
        return $clog2(levels + 1);
    endfunction

endpackage

// File: rtl/blink_rate_sel_if.sv
// Button inputs and blinker outputs bundled for the blinker core.
// The slave side is the blinker, the master side drives the buttons.
interface blink_rate_sel_if
    import blink_pkg::*;
#(
    parameter int LEVELS = 9
);

    localparam int LVL_W = lvl_w(LEVELS);

    logic             btn1;
    logic             btn2;
    logic             out;
    logic [LVL_W-1:0] level;
    logic             tick;

    modport master (
        output btn1,
        output btn2,
        input  out,
        input  level,
        input  tick
    );

    modport slave (
        input  btn1,
        input  btn2,
        output out,
        output level,
        output tick
    );

endinterface

// File: rtl/blink_rate_sel_btn_edge_sync.sv
// Two-flop synchroniser followed by a rising-edge detector.
// Inputs are assumed pre-debounced; a held button yields one pulse.
module btn_edge_sync (
    input  logic clk,
    input  logic _rst,
    input  logic btn,
    output logic pulse
);

    logic s1_q;
    logic s2_q;
    logic e_q;

    // Synchronise the button and keep the previous synchronised value.
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            e_q  <= 1'b0;
        end else begin
            s1_q <= btn;
            s2_q <= s1_q;
            e_q  <= s2_q;
        end
    end

    assign pulse = s2_q & ~e_q;

endmodule

// File: rtl/blink_rate_sel.sv
// Button-stepped blinker: prescaler tick, level register, phase counter.
// Output is either a level-scaled toggle or a level/LEVELS duty PWM.
module blink_rate_sel
    import blink_pkg::*;
#(
    parameter int LEVELS   = 9,
    parameter int TICK_DIV = 10000000,
    parameter int WRAP     = WRAP_SAT,
    parameter int MODE     = MODE_BLINK
) (
    input logic       clk,
    input logic       _rst,
    blink_rate_sel_if.slave bus
);

    localparam int LVL_W = lvl_w(LEVELS);
    localparam int CNT_W = $clog2(TICK_DIV);
    localparam int PH_W  = $clog2(LEVELS);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
    localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(LEVELS);
    localparam logic [LVL_W-1:0] LVL_ONE = LVL_W'(1);
    localparam logic [PH_W-1:0]  PH_MAX  = PH_W'(LEVELS - 1);

    logic             up;
    logic             dn;
    logic             tick;
    logic             chg;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LVL_W-1:0] lvl_q, lvl_d;
    logic [PH_W-1:0]  ph_q, ph_d;
    logic [PH_W-1:0]  ph_nxt;
    logic             out_q, out_d;

    btn_edge_sync u_up (
        .clk   (clk),
        ._rst  (_rst),
        .btn   (bus.btn1),
        .pulse (up)
    );

    btn_edge_sync u_dn (
        .clk   (clk),
        ._rst  (_rst),
        .btn   (bus.btn2),
        .pulse (dn)
    );

    // Free-running prescaler; tick marks its last count.
    always_comb begin
        tick  = (cnt_q == CNT_MAX);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    // Level stepping; simultaneous up and down presses cancel.
    always_comb begin
        lvl_d = lvl_q;
        if (up && !dn) begin
            if (lvl_q != LVL_MAX) begin
                lvl_d = lvl_q + 1'b1;
            end else if (WRAP == WRAP_ROLL) begin
                lvl_d = LVL_ONE;
            end
        end else if (dn && !up) begin
            if (lvl_q != LVL_ONE) begin
                lvl_d = lvl_q - 1'b1;
            end else if (WRAP == WRAP_ROLL) begin
                lvl_d = LVL_MAX;
            end
        end
        chg = (lvl_d != lvl_q);
    end

    // Phase and output update; a real level change restarts the phase.
    always_comb begin
        ph_d   = ph_q;
        out_d  = out_q;
        ph_nxt = (ph_q == PH_MAX) ? '0 : ph_q + 1'b1;
        if (chg) begin
            ph_d = '0;
        end else if (tick) begin
            if (MODE == MODE_PWM) begin
                ph_d  = ph_nxt;
                out_d = (LVL_W'(ph_nxt) < lvl_q);
            end else if (LVL_W'(ph_q) == lvl_q - 1'b1) begin
                ph_d  = '0;
                out_d = ~out_q;
            end else begin
                ph_d = ph_q + 1'b1;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            cnt_q <= '0;
            lvl_q <= LVL_ONE;
            ph_q  <= '0;
            out_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            lvl_q <= lvl_d;
            ph_q  <= ph_d;
            out_q <= out_d;
        end
    end

    assign bus.out   = out_q;
    assign bus.level = lvl_q;
    assign bus.tick  = tick;

endmodule

// File: tb/tb_blink_rate_sel.sv
// Bench for blink_rate_sel: three configurations share the buttons.
// Blink/saturate, blink/wrap and PWM/saturate run side by side.
module tb_blink_rate_sel;

    localparam int L  = 9;
    localparam int TD = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic b1    = 1'b0;
    logic b2    = 1'b0;

    int checks = 0;
    int errors = 0;

    blink_rate_sel_if #(.LEVELS(L)) bi0 ();
    blink_rate_sel_if #(.LEVELS(L)) bi1 ();
    blink_rate_sel_if #(.LEVELS(L)) bi2 ();

    assign bi0.btn1 = b1;
    assign bi0.btn2 = b2;
    assign bi1.btn1 = b1;
    assign bi1.btn2 = b2;
    assign bi2.btn1 = b1;
    assign bi2.btn2 = b2;

    blink_rate_sel #(
        .LEVELS(L), .TICK_DIV(TD), .WRAP(0), .MODE(0)
    ) d0 (
        .clk(clk), ._rst(rst_n), .bus(bi0)
    );

    blink_rate_sel #(
        .LEVELS(L), .TICK_DIV(TD), .WRAP(1), .MODE(0)
    ) d1 (
        .clk(clk), ._rst(rst_n), .bus(bi1)
    );

    blink_rate_sel #(
        .LEVELS(L), .TICK_DIV(TD), .WRAP(0), .MODE(1)
    ) d2 (
        .clk(clk), ._rst(rst_n), .bus(bi2)
    );

    logic       o  [3];
    logic [3:0] lv [3];
    logic       tk [3];

    assign o[0]  = bi0.out;
    assign o[1]  = bi1.out;
    assign o[2]  = bi2.out;
    assign lv[0] = bi0.level;
    assign lv[1] = bi1.level;
    assign lv[2] = bi2.level;
    assign tk[0] = bi0.tick;
    assign tk[1] = bi1.tick;
    assign tk[2] = bi2.tick;

    always #5 clk = ~clk;

    // Reference model: levels, phases, outputs and button history.
    int       mlvl [3];
    int       mph  [3];
    bit       mo   [3];
    int       mcnt;
    bit [2:0] h1;
    bit [2:0] h2;
    int       cw   [3] = '{0, 1, 0};
    int       cm   [3] = '{0, 0, 1};

    typedef struct {
        int nup;
        int ndn;
        int e0;
        int e1;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string nm, input int a, input int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", nm, a, e);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mlvl[i] = 1;
            mph[i]  = 0;
            mo[i]   = 1'b0;
        end
        mcnt = 0;
        h1   = '0;
        h2   = '0;
    endtask

    // A press acts on the level three edges after it is first sampled.
    task automatic model_step();
        bit p1;
        bit p2;
        bit tkm;
        int nl;
        p1  = h1[1] & ~h1[2];
        p2  = h2[1] & ~h2[2];
        tkm = (mcnt == TD - 1);
        for (int i = 0; i < 3; i++) begin
            nl = mlvl[i];
            if (p1 && !p2)
                nl = (mlvl[i] < L) ? mlvl[i] + 1 : (cw[i] != 0 ? 1 : L);
            else if (p2 && !p1)
                nl = (mlvl[i] > 1) ? mlvl[i] - 1 : (cw[i] != 0 ? L : 1);
            if (nl != mlvl[i]) begin
                mlvl[i] = nl;
                mph[i]  = 0;
            end else if (tkm) begin
                if (cm[i] == 0) begin
                    if (mph[i] == mlvl[i] - 1) begin
                        mo[i]  = !mo[i];
                        mph[i] = 0;
                    end else begin
                        mph[i]++;
                    end
                end else begin
                    mph[i] = (mph[i] + 1) % L;
                    mo[i]  = (mph[i] < mlvl[i]);
                end
            end
        end
        mcnt = (mcnt + 1) % TD;
        h1   = {h1[1:0], b1};
        h2   = {h2[1:0], b2};
    endtask

    // One clock: advance the model, then compare on the falling edge.
    task automatic cyc();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("out%0d", i), int'(o[i]), int'(mo[i]));
            chk($sformatf("level%0d", i), int'(lv[i]), mlvl[i]);
            chk($sformatf("tick%0d", i), int'(tk[i]), int'(mcnt == TD - 1));
        end
    endtask

    task automatic press(input bit up);
        if (up) b1 = 1'b1;
        else    b2 = 1'b1;
        repeat (4) cyc();
        b1 = 1'b0;
        b2 = 1'b0;
        repeat (4) cyc();
    endtask

    // Async reset mid-cycle, then first-tick timing after release.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_out%0d", i), int'(o[i]), 0);
            chk($sformatf("rst_level%0d", i), int'(lv[i]), 1);
            chk($sformatf("rst_tick%0d", i), int'(tk[i]), 0);
        end
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("first_tick_c1", int'(tk[0]), 0);
        cyc();
        chk("first_tick_c2", int'(tk[0]), 0);
        cyc();
        chk("first_tick_c3", int'(tk[0]), 1);
        repeat (3) cyc();
        chk("second_tick_c6", int'(tk[0]), 0);
        cyc();
        chk("second_tick_c7", int'(tk[0]), 1);
    endtask

    task automatic run_len(input int i, output int n);
        bit v;
        int k;
        v = o[i];
        k = 0;
        while (o[i] == v && k < 400) begin
            cyc();
            k++;
        end
        v = o[i];
        n = 0;
        while (o[i] == v && n < 400) begin
            cyc();
            n++;
        end
    endtask

    task automatic edge_to(input int i, input bit v);
        int k;
        k = 0;
        while (o[i] == v && k < 400) begin
            cyc();
            k++;
        end
        while (o[i] != v && k < 800) begin
            cyc();
            k++;
        end
    endtask

    task automatic cnt_while(input int i, input bit v, output int n);
        n = 0;
        while (o[i] == v && n < 400) begin
            cyc();
            n++;
        end
    endtask

    initial begin
        int n;
        int k;
        int z;

        tbl[0] = '{2, 0, 3, 3};
        tbl[1] = '{8, 0, 9, 2};
        tbl[2] = '{0, 1, 8, 1};
        tbl[3] = '{0, 9, 1, 1};
        tbl[4] = '{0, 1, 1, 9};
        tbl[5] = '{1, 0, 2, 1};

        do_reset();

        run_len(0, n);
        chk("blink_l1_half", n, 4);

        for (int r = 0; r < 6; r++) begin
            repeat (tbl[r].nup) press(1'b1);
            repeat (tbl[r].ndn) press(1'b0);
            chk($sformatf("tbl%0d_sat", r), int'(lv[0]), tbl[r].e0);
            chk($sformatf("tbl%0d_wrap", r), int'(lv[1]), tbl[r].e1);
            chk($sformatf("tbl%0d_pwm", r), int'(lv[2]), tbl[r].e0);
        end

        b1 = 1'b1;
        cyc();
        chk("lat_edge1", int'(lv[0]), 2);
        cyc();
        chk("lat_edge2", int'(lv[0]), 2);
        cyc();
        chk("lat_edge3", int'(lv[0]), 3);
        chk("lat_edge3_wrap", int'(lv[1]), 2);
        b1 = 1'b0;
        repeat (4) cyc();

        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 5) == 0) b1 = ~b1;
            if ($urandom_range(0, 5) == 0) b2 = ~b2;
            cyc();
        end
        b1 = 1'b0;
        b2 = 1'b0;
        repeat (6) cyc();

        k = 0;
        while (!o[0] && k < 200) begin
            cyc();
            k++;
        end
        chk("pre_rst_out", int'(o[0]), 1);
        do_reset();

        press(1'b1);
        press(1'b1);
        chk("up2_level", int'(lv[0]), 3);
        run_len(0, n);
        chk("blink_l3_half", n, 12);

        edge_to(2, 1'b1);
        cnt_while(2, 1'b1, n);
        chk("pwm_l3_high", n, 12);
        cnt_while(2, 1'b0, n);
        chk("pwm_l3_low", n, 24);

        edge_to(2, 1'b1);
        repeat (2) cyc();
        press(1'b1);
        chk("mid_frame_level", int'(lv[2]), 4);
        edge_to(2, 1'b1);
        cnt_while(2, 1'b1, n);
        chk("pwm_l4_high", n, 16);
        cnt_while(2, 1'b0, n);
        chk("pwm_l4_low", n, 20);

        b1 = 1'b1;
        repeat (100) cyc();
        b1 = 1'b0;
        repeat (4) cyc();
        chk("hold_sat", int'(lv[0]), 5);
        chk("hold_wrap", int'(lv[1]), 5);

        b1 = 1'b1;
        b2 = 1'b1;
        repeat (6) cyc();
        b1 = 1'b0;
        b2 = 1'b0;
        repeat (4) cyc();
        chk("both_sat", int'(lv[0]), 5);
        chk("both_wrap", int'(lv[1]), 5);

        repeat (4) press(1'b1);
        chk("up_to_max", int'(lv[2]), 9);
        repeat (8) cyc();
        z = 0;
        repeat (40) begin
            cyc();
            if (!o[2]) z++;
        end
        chk("pwm_l9_zeros", z, 0);

        press(1'b1);
        chk("max_up_sat", int'(lv[0]), 9);
        chk("max_up_wrap", int'(lv[1]), 1);
        chk("max_up_pwm", int'(lv[2]), 9);

        do_reset();
        press(1'b0);
        chk("min_dn_sat", int'(lv[0]), 1);
        chk("min_dn_wrap", int'(lv[1]), 9);
        repeat (4) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/blink_rate_sel.md
Name: blink_rate_sel

Overview:
- Button-controlled output blinker with selectable rate: two push-buttons step a level up/down across LEVELS settings.
- A free-running prescaler produces a one-cycle tick enable, and a single phase counter drives the output.
- Generalises the fixed 9-rate, one-hot, derived-clock blinker:
  - parametrised level count;
  - saturate or wrap stepping;
  - blink or PWM mode;
  - single clock domain with clock enables, no generated clocks.

Parameters:
- LEVELS, 9, number of selectable levels (>=2); level range 1..LEVELS.
- TICK_DIV, 10000000, clk cycles per tick (>=2).
- WRAP, 0, 0 = saturate at 1/LEVELS, 1 = wrap LEVELS<->1.
- MODE, 0, 0 = blink (toggle), 1 = PWM (duty level/LEVELS).
- LVL_W, $clog2(LEVELS+1), width of level port (derived, not overridden).

Ports:
- clk     input   1       system clock, all logic on rising edge
- _rst    input   1       asynchronous active-low reset
- btn1    input   1       step-up button, asynchronous, active-high
- btn2    input   1       step-down button, asynchronous, active-high
- out     output  1       registered blink/PWM output
- level   output  LVL_W   current level, 1..LEVELS
- tick    output  1       one-cycle prescaler tick (debug/chaining)

Behaviour:
- Reset (_rst=0, async): out=0, level=1, tick=0, all counters and sync flops 0. Deassertion takes effect on the next rising clk.
- Button path, per button:
  - 2-flop synchroniser, then an edge register; pulse = sync2 & ~edge_reg, one cycle per rising press.
  - Held button gives exactly one step. No debouncing in this block; inputs are pre-debounced.
  - Latency: level changes on the 3rd rising clk edge after btn rises, given setup is met.
- Both pulses in the same cycle: ignored, level unchanged.
- Up pulse:
  - level<LEVELS: level+1.
  - level==LEVELS: stays LEVELS if WRAP=0, else 1.
- Down pulse:
  - level>1: level-1.
  - level==1: stays 1 if WRAP=0, else LEVELS.
- Any actual level change clears the phase counter. out and prescaler are unaffected. A saturated (no-change) press clears nothing.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps; free-running, never cleared except by reset.
  - tick=1 for exactly the cycle where count==TICK_DIV-1. First tick is in clk cycle TICK_DIV after reset release.
- Blink mode (MODE=0):
  - On tick: if phase==level-1, out toggles and phase clears to 0; else phase+1.
  - out half-period = level ticks, i.e. level*TICK_DIV clk cycles.
- PWM mode (MODE=1):
  - On tick, phase advances 0..LEVELS-1 and wraps.
  - out is registered, out <= (phase_next < level), updated on tick cycles only.
  - level==LEVELS gives constant 1 after the first tick; no 0% duty exists.
- Phase counter width: $clog2(LEVELS); no overflow possible because the compare bounds it.
- Simultaneous tick and level change: the level-change clear wins; phase=0, no toggle that cycle.

Decomposition:
- Package blink_pkg:
  - MODE_BLINK=0, MODE_PWM=1 constants.
  - WRAP_SAT=0, WRAP_ROLL=1 constants.
- Sub-module btn_edge_sync: synchroniser plus rising-edge pulse, ports clk, _rst, btn, pulse; instantiated twice.
- Prescaler, level register and phase/output logic stay in blink_rate_sel.

Test Plan (TICK_DIV=4, LEVELS=9 unless stated):
- Reset: hold _rst=0 mid-run with out=1 -> out=0 and level=1 immediately, without waiting for clk. Release -> first tick at cycle 4, then every 4 cycles.
- Blink, level 1: out toggles every 4 clk. Pulse btn1 twice -> level=3 on the 3rd edge after each press; out half-period becomes 12 clk.
- Stepping limits, WRAP=0: at level 9, btn1 -> level stays 9; at level 1, btn2 -> level stays 1.
- Stepping limits, WRAP=1: 9 + btn1 -> 1; 1 + btn2 -> 9.
- Presses: btn1 held high for 100 cycles -> exactly one step. btn1 and btn2 rising in the same cycle -> level unchanged.
- PWM, MODE=1:
  - level=3: out high 12 clk, low 24 clk, period 36 clk.
  - level=9: out constant 1 after the first tick.
  - Step 3->4 mid-frame: phase restarts at 0, new duty 16/36 clk.
